// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch engine.
//
// Issues one instruction-memory read per enfetch strobe, waits for imem_ack
// (bounded by TIMEOUT cycles), loads the instruction register and advances
// the PC by one or to a branch target. A fetch that times out loads NOP and
// sets the sticky fetch_err flag.
//
// Handshake: a request is outstanding while imem_req=1. imem_req and
// imem_addr are registered and held stable until the cycle after the memory
// answers with imem_ack=1 (or the timeout fires). imem_ack/imem_rdata are
// looked at only while a request is outstanding; in any other cycle they are
// ignored.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   enfetch        one-cycle fetch strobe (ignored while a fetch is outstanding)
//   br_taken       redirect request, qualifies br_target
//   br_target      redirect address
//   imem_req       read request to instruction memory
//   imem_addr      read address
//   imem_ack       read data valid
//   imem_rdata     read data
//   ir, ir_valid   instruction register and its valid flag
//   pc             address of the next instruction to fetch
//   stall          high while a fetch is outstanding (this is the FSM state)
//   fetch_err      sticky timeout flag, cleared only by rst
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 15,
  parameter logic [15:0]       NOP      = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enfetch,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              stall,
  output logic              fetch_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Counter value on the last WAIT cycle before the timeout fires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_d;
  logic [7:0]        cnt, cnt_d;
  logic              pend_valid, pend_valid_d;
  logic [ADDR_W-1:0] pend_target, pend_target_d;
  logic [ADDR_W-1:0] pc_d, addr_d;
  logic [15:0]       ir_d;
  logic              ir_valid_d, req_d, err_d;

  assign stall = (state == S_WAIT);

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    pend_valid_d  = pend_valid;
    pend_target_d = pend_target;
    pc_d          = pc;
    addr_d        = imem_addr;
    ir_d          = ir;
    ir_valid_d    = ir_valid;
    req_d         = imem_req;
    err_d         = fetch_err;

    case (state)
      S_IDLE: begin
        if (br_taken) pc_d = br_target;
        if (enfetch) begin
          state_d    = S_WAIT;
          req_d      = 1'b1;
          addr_d     = pc;
          ir_valid_d = 1'b0;
          cnt_d      = 8'd0;
          // The fetch goes out at the old pc; remembering the target as a
          // pending redirect keeps completion from incrementing past it.
          if (br_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = br_target;
          end
        end
      end

      S_WAIT: begin
        if (imem_ack || (cnt == CNT_LAST)) begin
          // Completion; an ack on the last counted cycle still wins.
          state_d      = S_IDLE;
          req_d        = 1'b0;
          ir_valid_d   = 1'b1;
          pend_valid_d = 1'b0;
          if (imem_ack) begin
            ir_d = imem_rdata;
          end else begin
            ir_d  = NOP;
            err_d = 1'b1;
          end
          // A live redirect beats the pending one.
          if (br_taken)        pc_d = br_target;
          else if (pend_valid) pc_d = pend_target;
          else                 pc_d = pc + ADDR_W'(1);
        end else begin
          cnt_d = cnt + 8'd1;
          if (br_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = br_target;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      pc          <= RESET_PC;
      imem_addr   <= '0;
      imem_req    <= 1'b0;
      ir          <= 16'h0000;
      ir_valid    <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pend_valid  <= pend_valid_d;
      pend_target <= pend_target_d;
      pc          <= pc_d;
      imem_addr   <= addr_d;
      imem_req    <= req_d;
      ir          <= ir_d;
      ir_valid    <= ir_valid_d;
      fetch_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an expected-instruction
// queue. Each fetch pushes the instruction word it should produce; the word is
// popped and compared once the fetch completes.
module tb_fetch_unit;

  localparam int          ADDR_W  = 8;
  localparam int          TIMEOUT = 15;
  localparam logic [15:0] NOP     = 16'h0000;
  localparam logic [7:0]  RST_PC  = 8'h00;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enfetch = 1'b0;
  logic        br_taken = 1'b0;
  logic [7:0]  br_target = 8'h00;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] ir;
  logic        ir_valid;
  logic [7:0]  pc;
  logic        stall;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RST_PC),
    .TIMEOUT  (TIMEOUT),
    .NOP      (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enfetch    (enfetch),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .stall      (stall),
    .fetch_err  (fetch_err)
  );

  // ---------------- scoreboard state ----------------
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  m_pc;
  logic        m_err;
  logic [15:0] m_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst      = 1'b1;
    enfetch  = 1'b0;
    br_taken = 1'b0;
    imem_ack = 1'b0;
    step();
    step();
    rst   = 1'b0;
    m_pc  = RST_PC;
    m_err = 1'b0;
    m_ir  = 16'h0000;
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".pc"},        pc,        RST_PC);
    chk({tag, ".ir"},        ir,        16'h0000);
    chk({tag, ".ir_valid"},  ir_valid,  1'b0);
    chk({tag, ".imem_req"},  imem_req,  1'b0);
    chk({tag, ".imem_addr"}, imem_addr, 8'h00);
    chk({tag, ".fetch_err"}, fetch_err, 1'b0);
    chk({tag, ".stall"},     stall,     1'b0);
  endtask

  task automatic idle_branch(input string tag, input logic [7:0] tgt);
    br_taken  = 1'b1;
    br_target = tgt;
    step();
    br_taken = 1'b0;
    chk({tag, ".pc"},    pc,    tgt);
    chk({tag, ".stall"}, stall, 1'b0);
    m_pc = tgt;
  endtask

  // One fetch. ack_at: WAIT cycle (1-based) carrying the ack, 0 = never.
  // br_at / br2_at: WAIT cycle of a redirect, 0 = together with enfetch,
  // -1 = none. br2 always comes later than br.
  task automatic fetch(input string tag, input int ack_at, input logic [15:0] rdata,
                       input int br_at, input logic [7:0] tgt,
                       input int br2_at, input logic [7:0] tgt2);
    logic [7:0]  addr;
    logic [7:0]  pc_after;
    logic [15:0] exp_ir;
    int          last;
    bit          acked;
    acked    = (ack_at >= 1) && (ack_at <= TIMEOUT);
    last     = acked ? ack_at : TIMEOUT;
    addr     = m_pc;
    pc_after = m_pc + 8'd1;
    if (br_at  >= 0 && br_at  <= last) pc_after = tgt;
    if (br2_at >= 0 && br2_at <= last) pc_after = tgt2;
    if (acked) exp_q.push_back(rdata);
    else begin
      exp_q.push_back(NOP);
      m_err = 1'b1;
    end

    enfetch = 1'b1;
    if (br_at == 0) begin
      br_taken  = 1'b1;
      br_target = tgt;
    end
    step();
    enfetch  = 1'b0;
    br_taken = 1'b0;
    chk({tag, ".ir_valid_wait"}, ir_valid, 1'b0);

    for (int w = 1; w <= last; w++) begin
      chk({tag, ".stall"},     stall,     1'b1);
      chk({tag, ".imem_req"},  imem_req,  1'b1);
      chk({tag, ".imem_addr"}, imem_addr, addr);
      if (w == br_at) begin
        br_taken  = 1'b1;
        br_target = tgt;
      end
      if (w == br2_at) begin
        br_taken  = 1'b1;
        br_target = tgt2;
      end
      if (w == ack_at) begin
        imem_ack   = 1'b1;
        imem_rdata = rdata;
      end else begin
        imem_rdata = 16'($urandom_range(0, 16'hFFFF));
      end
      step();
      imem_ack = 1'b0;
      br_taken = 1'b0;
    end

    chk({tag, ".stall_end"}, stall,     1'b0);
    chk({tag, ".req_end"},   imem_req,  1'b0);
    chk({tag, ".ir_valid"},  ir_valid,  1'b1);
    chk({tag, ".queue"},     32'(exp_q.size()), 32'd1);
    exp_ir = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    chk({tag, ".ir"},        ir,        exp_ir);
    chk({tag, ".pc"},        pc,        pc_after);
    chk({tag, ".fetch_err"}, fetch_err, m_err);
    m_pc = pc_after;
    m_ir = exp_ir;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();
    check_reset_state("reset");

    // Basic fetch, ack on third WAIT cycle.
    fetch("basic", 3, 16'hA5C3, -1, 8'h00, -1, 8'h00);

    // Ack while idle changes nothing.
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0;
    chk("idle_ack.ir",       ir,       m_ir);
    chk("idle_ack.ir_valid", ir_valid, 1'b1);
    chk("idle_ack.pc",       pc,       m_pc);
    chk("idle_ack.req",      imem_req, 1'b0);

    // Timeout, then a good fetch keeps the sticky error.
    fetch("timeout", 0, 16'h0000, -1, 8'h00, -1, 8'h00);
    fetch("after_to", 2, 16'h1111, -1, 8'h00, -1, 8'h00);

    do_reset();
    check_reset_state("reset2");

    // Branch during WAIT from pc=8.
    idle_branch("br_idle", 8'h08);
    fetch("br_wait", 4, 16'h2222, 1, 8'h40, -1, 8'h00);
    // Pending overwritten by a later branch.
    fetch("br_overwrite", 4, 16'h3333, 1, 8'h30, 2, 8'h70);
    // Live branch on the ack cycle beats the pending one.
    fetch("br_live", 3, 16'h4444, 1, 8'h30, 3, 8'h60);
    // Plain fetch after a redirect: pending must be cleared.
    fetch("post_br", 1, 16'h5555, -1, 8'h00, -1, 8'h00);

    // PC wrap.
    idle_branch("br_ff", 8'hFF);
    fetch("wrap", 1, 16'h6666, -1, 8'h00, -1, 8'h00);

    // enfetch and br_taken together in IDLE.
    fetch("collide", 2, 16'h7777, 0, 8'h10, -1, 8'h00);

    // Randomized ack latencies.
    for (int i = 0; i < 4; i++) begin
      fetch("rand", int'($urandom_range(1, TIMEOUT - 1)), 16'($urandom_range(0, 16'hFFFF)),
            -1, 8'h00, -1, 8'h00);
    end

    // Ack on the same cycle the timeout would fire.
    fetch("tie", TIMEOUT, 16'h9ABC, -1, 8'h00, -1, 8'h00);

    // Reset mid-fetch, late ack afterwards.
    do_reset();
    enfetch = 1'b1;
    step();
    enfetch = 1'b0;
    step();
    chk("rst_mid.wait2_stall", stall, 1'b1);
    rst = 1'b1;
    step();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'h1234;
    chk("rst_mid.req_drop", imem_req, 1'b0);
    step();
    imem_ack = 1'b0;
    check_reset_state("rst_mid");
    step();
    chk("rst_mid.late_ir",    ir,       16'h0000);
    chk("rst_mid.late_valid", ir_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
